uart_rx_16x: RTL

- UART receiver for 16x oversampling. It consumes the single-cycle o_16x_baud_en pulse from uart_baud_rate, using a common clk and the same parameter set.
- It synchronises the serial input, detects and qualifies the start bit, and samples each bit at mid-bit.
- It delivers one parallel word per frame as a one-cycle valid pulse, with frame and parity error flags.
- It sits between the pad-side rxd pin and the byte-level consumer (register bank or FIFO).

---
 rtl/uart_rx_16x.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_16x.sv
// 16x-oversampled UART receiver: two-flop input synchroniser, start-bit
// qualification at mid-start, mid-bit sampling, optional parity, break handling.
module uart_rx_16x #(
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_16x_baud_en,
    input  logic                 i_rxd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } state_e;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [3:0] TICK_MID  = 4'd7;
    localparam logic [3:0] TICK_LAST = 4'd15;

    state_e               state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 sync1_q, rxd_s_q;

    // Synchroniser flops reset to the idle level so a reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
        end else begin
            sync1_q <= i_rxd;
            rxd_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;

        if (i_16x_baud_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxd_s_q) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end
                end

                ST_START: begin
                    if (tick_q == TICK_MID) begin
                        if (!rxd_s_q) begin
                            state_d   = ST_DATA;
                            tick_d    = '0;
                            bit_d     = '0;
                            par_err_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end

                // Counting restarts at mid-start, so tick 15 lands at mid-bit.
                ST_DATA: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == LAST_BIT) begin
                            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                        end
                    end
                end

                ST_PARITY: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        par_err_d = ((^shift_q) ^ rxd_s_q) != PARITY_ODD;
                        state_d   = ST_STOP;
                    end
                end

                ST_STOP: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        data_d       = shift_q;
                        valid_d      = 1'b1;
                        frame_err_d  = ~rxd_s_q;
                        parity_err_d = PARITY_EN ? par_err_q : 1'b0;
                        state_d      = rxd_s_q ? ST_IDLE : ST_BREAK_WAIT;
                    end
                end

                ST_BREAK_WAIT: begin
                    if (rxd_s_q) begin
                        state_d = ST_IDLE;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_frame_err  = frame_err_q;
    assign o_parity_err = parity_err_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule
